// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order reorder buffer controller.
// Hands out ROB tags at issue, captures CDB results, and retires the head
// entry in program order onto the regfile commit port. Stores at head wait
// for the LSB to finish. A mispredicted branch at head retires its value,
// then raises a one-cycle flush with the redirect PC.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   in_issue_*   : decoder allocation request; out_issue_tag = tail, out_full
//   in_cdb_*     : result broadcast (value, mispredict, target)
//   in_query_tag*/out_query_* : combinational operand lookup with CDB bypass
//   out_commit_* : registered commit pulse (reg 0 = nothing committed)
//   out_store_commit / in_store_done : LSB store handshake
//   out_xbp / out_redirect_pc : flush pulse and correct fetch PC
module rob_commit_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_W     = 4,
  parameter int REG_W     = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_issue_valid,
  input  logic [REG_W-1:0]  in_issue_dest_reg,
  input  logic              in_issue_is_store,
  input  logic [DATA_W-1:0] in_issue_pc,
  output logic [ROB_W-1:0]  out_issue_tag,
  output logic              out_full,
  input  logic              in_cdb_valid,
  input  logic [ROB_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic              in_cdb_mispredict,
  input  logic [DATA_W-1:0] in_cdb_target,
  input  logic [ROB_W-1:0]  in_query_tag1,
  input  logic [ROB_W-1:0]  in_query_tag2,
  output logic              out_query_ready1,
  output logic              out_query_ready2,
  output logic [DATA_W-1:0] out_query_value1,
  output logic [DATA_W-1:0] out_query_value2,
  output logic [REG_W-1:0]  out_commit_reg,
  output logic [ROB_W-1:0]  out_commit_rob,
  output logic [DATA_W-1:0] out_commit_value,
  output logic              out_store_commit,
  input  logic              in_store_done,
  output logic              out_xbp,
  output logic [DATA_W-1:0] out_redirect_pc
);

  typedef enum logic [1:0] {RUN, WAIT_STORE, FLUSH} state_t;

  localparam logic [ROB_W:0]   CNT_ONE  = (ROB_W+1)'(1);
  localparam logic [ROB_W:0]   CNT_FULL = (ROB_W+1)'(ROB_DEPTH);
  localparam logic [ROB_W-1:0] PTR_ONE  = ROB_W'(1);

  state_t state, state_nxt;

  logic [ROB_DEPTH-1:0] busy, done, is_st, mis;
  logic [REG_W-1:0]     dest [ROB_DEPTH];
  logic [DATA_W-1:0]    val  [ROB_DEPTH];
  // Holds the issuing PC until a branch resolves, then the correct target.
  logic [DATA_W-1:0]    tgt  [ROB_DEPTH];

  logic [ROB_W-1:0] head, tail;
  logic [ROB_W:0]   count;

  logic alloc, wb, head_ok;
  logic retire, emit_commit, emit_store, emit_xbp;
  logic byp1, byp2;

  assign out_full      = (count == CNT_FULL);
  assign out_issue_tag = tail;

  assign alloc   = in_issue_valid && !out_full && (state != FLUSH);
  assign wb      = in_cdb_valid && busy[in_cdb_tag] && (state != FLUSH);
  assign head_ok = busy[head] && done[head];

  // Operand lookup: a result on the CDB this cycle is forwarded directly.
  assign byp1 = in_cdb_valid && (in_cdb_tag == in_query_tag1);
  assign byp2 = in_cdb_valid && (in_cdb_tag == in_query_tag2);
  assign out_query_ready1 = byp1 || (busy[in_query_tag1] && done[in_query_tag1]);
  assign out_query_ready2 = byp2 || (busy[in_query_tag2] && done[in_query_tag2]);
  assign out_query_value1 = byp1 ? in_cdb_value :
                            ((busy[in_query_tag1] && done[in_query_tag1]) ? val[in_query_tag1] : '0);
  assign out_query_value2 = byp2 ? in_cdb_value :
                            ((busy[in_query_tag2] && done[in_query_tag2]) ? val[in_query_tag2] : '0);

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    emit_commit = 1'b0;
    emit_store  = 1'b0;
    emit_xbp    = 1'b0;
    case (state)
      RUN: begin
        if (head_ok) begin
          if (mis[head]) begin
            // Head is not advanced: the flush cycle wipes the whole buffer.
            emit_commit = 1'b1;
            emit_xbp    = 1'b1;
            state_nxt   = FLUSH;
          end else if (is_st[head]) begin
            emit_store = 1'b1;
            state_nxt  = WAIT_STORE;
          end else begin
            emit_commit = 1'b1;
            retire      = 1'b1;
          end
        end
      end
      WAIT_STORE: begin
        if (in_store_done) begin
          retire    = 1'b1;
          state_nxt = RUN;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      done             <= '0;
      out_commit_reg   <= '0;
      out_commit_rob   <= '0;
      out_commit_value <= '0;
      out_store_commit <= 1'b0;
      out_xbp          <= 1'b0;
      out_redirect_pc  <= '0;
    end else begin
      // Commit outputs are single-cycle pulses.
      out_commit_reg   <= '0;
      out_store_commit <= 1'b0;
      out_xbp          <= 1'b0;
      if (rdy) begin
        state <= state_nxt;
        if (state == FLUSH) begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
          busy  <= '0;
          done  <= '0;
        end else begin
          if (alloc) begin
            busy[tail]  <= 1'b1;
            done[tail]  <= 1'b0;
            is_st[tail] <= in_issue_is_store;
            mis[tail]   <= 1'b0;
            dest[tail]  <= in_issue_dest_reg;
            tgt[tail]   <= in_issue_pc;
            tail        <= tail + PTR_ONE;
          end
          if (wb) begin
            done[in_cdb_tag] <= 1'b1;
            val[in_cdb_tag]  <= in_cdb_value;
            mis[in_cdb_tag]  <= in_cdb_mispredict;
            tgt[in_cdb_tag]  <= in_cdb_target;
          end
          if (retire) begin
            busy[head] <= 1'b0;
            head       <= head + PTR_ONE;
          end
          case ({alloc, retire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
          endcase
        end
        if (emit_commit) begin
          out_commit_reg   <= dest[head];
          out_commit_rob   <= head;
          out_commit_value <= val[head];
        end
        if (emit_store) begin
          out_commit_rob   <= head;
          out_store_commit <= 1'b1;
        end
        if (emit_xbp) begin
          out_xbp         <= 1'b1;
          out_redirect_pc <= tgt[head];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_issue_valid, in_issue_is_store;
  logic [4:0]  in_issue_dest_reg;
  logic [31:0] in_issue_pc;
  logic [3:0]  out_issue_tag;
  logic        out_full;
  logic        in_cdb_valid, in_cdb_mispredict;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value, in_cdb_target;
  logic [3:0]  in_query_tag1, in_query_tag2;
  logic        out_query_ready1, out_query_ready2;
  logic [31:0] out_query_value1, out_query_value2;
  logic [4:0]  out_commit_reg;
  logic [3:0]  out_commit_rob;
  logic [31:0] out_commit_value;
  logic        out_store_commit, in_store_done, out_xbp;
  logic [31:0] out_redirect_pc;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_issue_valid(in_issue_valid), .in_issue_dest_reg(in_issue_dest_reg),
    .in_issue_is_store(in_issue_is_store), .in_issue_pc(in_issue_pc),
    .out_issue_tag(out_issue_tag), .out_full(out_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_mispredict(in_cdb_mispredict), .in_cdb_target(in_cdb_target),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value), .out_store_commit(out_store_commit),
    .in_store_done(in_store_done), .out_xbp(out_xbp), .out_redirect_pc(out_redirect_pc)
  );

  always #5 clk = ~clk;

  // kind: 0 = register commit, 1 = store release, 2 = mispredict commit + flush
  typedef struct {
    int          kind;
    logic [4:0]  rg;
    logic [3:0]  rob;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   commit_cyc[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   store_seen, xbp_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every commit-side event must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (!rst && (out_commit_reg != 0 || out_store_commit || out_xbp)) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_commit: got reg=%0d rob=%0d st=%0b xbp=%0b, none expected",
                 out_commit_reg, out_commit_rob, out_store_commit, out_xbp);
      end else begin
        e = exp_q.pop_front();
        commit_cyc.push_back(cyc);
        case (e.kind)
          1: begin
            bad = (out_store_commit !== 1'b1) || (out_commit_rob !== e.rob) ||
                  (out_xbp !== 1'b0) || (out_commit_reg !== 5'd0);
            store_seen = 1'b1;
          end
          2: begin
            bad = (out_xbp !== 1'b1) || (out_commit_reg !== e.rg) || (out_commit_rob !== e.rob) ||
                  (out_commit_value !== e.val) || (out_redirect_pc !== e.pc) || (out_store_commit !== 1'b0);
            xbp_seen = 1'b1;
          end
          default:
            bad = (out_commit_reg !== e.rg) || (out_commit_rob !== e.rob) ||
                  (out_commit_value !== e.val) || (out_store_commit !== 1'b0) || (out_xbp !== 1'b0);
        endcase
        if (bad)
          $display("FAIL commit_kind%0d: got reg=%0d rob=%0d val=%h st=%0b xbp=%0b pc=%h, want reg=%0d rob=%0d val=%h pc=%h",
                   e.kind, out_commit_reg, out_commit_rob, out_commit_value, out_store_commit,
                   out_xbp, out_redirect_pc, e.rg, e.rob, e.val, e.pc);
        else passes++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_issue_valid = 0; in_issue_is_store = 0; in_issue_dest_reg = 0; in_issue_pc = 0;
    in_cdb_valid = 0; in_cdb_mispredict = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_target = 0;
    in_query_tag1 = 0; in_query_tag2 = 0; in_store_done = 0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    commit_cyc.delete();
    store_seen = 0; xbp_seen = 0;
  endtask

  task automatic issue(input logic [4:0] d, input logic st, input logic [31:0] pc);
    in_issue_valid = 1; in_issue_dest_reg = d; in_issue_is_store = st; in_issue_pc = pc;
    tick();
    in_issue_valid = 0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic m, input logic [31:0] tg);
    in_cdb_valid = 1; in_cdb_tag = t; in_cdb_value = v; in_cdb_mispredict = m; in_cdb_target = tg;
    tick();
    in_cdb_valid = 0; in_cdb_mispredict = 0;
  endtask

  task automatic push(input int k, input logic [4:0] r, input logic [3:0] t,
                      input logic [31:0] v, input logic [31:0] pc);
    exp_t e;
    e.kind = k; e.rg = r; e.rob = t; e.val = v; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      tick();
    end
    if (exp_q.size() == 0) ok = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_issue_valid = 0; in_cdb_valid = 0; in_store_done = 0;
    in_query_tag1 = 0; in_query_tag2 = 3;
    tick(); tick();
    checks++;
    if ({out_full, out_issue_tag, out_commit_reg, out_commit_rob, out_store_commit, out_xbp} !== '0)
      $display("FAIL reset_ctrl: got full=%0b tag=%0d reg=%0d rob=%0d st=%0b xbp=%0b, want all 0",
               out_full, out_issue_tag, out_commit_reg, out_commit_rob, out_store_commit, out_xbp);
    else passes++;
    checks++;
    if ({out_commit_value, out_redirect_pc} !== 64'd0)
      $display("FAIL reset_data: got val=%h pc=%h, want 0", out_commit_value, out_redirect_pc);
    else passes++;
    checks++;
    if ({out_query_ready1, out_query_ready2, out_query_value1, out_query_value2} !== '0)
      $display("FAIL reset_query: got r1=%0b r2=%0b v1=%h v2=%h, want 0",
               out_query_ready1, out_query_ready2, out_query_value1, out_query_value2);
    else passes++;
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    issue(5'd1, 0, 32'h100);
    push(0, 5'd1, 4'd0, 32'h5, 0);
    cdb(4'd0, 32'h5, 0, 0);
    drain(10, ok);
    checks++;
    if (!ok) $display("FAIL basic_timeout: %0d commits left, want 0", exp_q.size()); else passes++;
    tick();
    checks++;
    if (out_issue_tag !== 4'd1 || out_full !== 1'b0)
      $display("FAIL basic_ptr: got tag=%0d full=%0b, want tag=1 full=0", out_issue_tag, out_full);
    else passes++;
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) issue(5'(i + 1), 0, 32'(i * 4));
    checks++;
    if (out_full !== 1'b1 || out_issue_tag !== 4'd0)
      $display("FAIL full_set: got full=%0b tag=%0d, want full=1 tag=0", out_full, out_issue_tag);
    else passes++;
    issue(5'd20, 0, 32'hdead);
    checks++;
    if (out_full !== 1'b1 || out_issue_tag !== 4'd0)
      $display("FAIL full_ignore: got full=%0b tag=%0d, want full=1 tag=0", out_full, out_issue_tag);
    else passes++;
    push(0, 5'd1, 4'd0, 32'h100, 0);
    cdb(4'd0, 32'h100, 0, 0);
    drain(10, ok);
    tick();
    checks++;
    if (!ok || out_full !== 1'b0)
      $display("FAIL full_drop: got full=%0b pending=%0d, want full=0 pending=0", out_full, exp_q.size());
    else passes++;
    for (int i = 1; i < 16; i++) begin
      push(0, 5'(i + 1), 4'(i), 32'h100 + 32'(i), 0);
      cdb(4'(i), 32'h100 + 32'(i), 0, 0);
    end
    drain(40, ok);
    checks++;
    if (!ok || out_full !== 1'b0 || out_issue_tag !== 4'd0)
      $display("FAIL full_drain: got pending=%0d full=%0b tag=%0d, want 0/0/0",
               exp_q.size(), out_full, out_issue_tag);
    else passes++;
  endtask

  task automatic test_ooo();
    bit ok;
    do_reset();
    issue(5'd3, 0, 0); issue(5'd4, 0, 4); issue(5'd5, 0, 8);
    cdb(4'd2, 32'h22, 0, 0);
    in_query_tag1 = 4'd2; in_query_tag2 = 4'd0; #1;
    checks++;
    if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'h22 || out_query_ready2 !== 1'b0)
      $display("FAIL query_store: got r1=%0b v1=%h r2=%0b, want r1=1 v1=22 r2=0",
               out_query_ready1, out_query_value1, out_query_ready2);
    else passes++;
    in_cdb_valid = 1; in_cdb_tag = 4'd1; in_cdb_value = 32'h11; in_cdb_mispredict = 0;
    in_query_tag1 = 4'd1; #1;
    checks++;
    if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'h11)
      $display("FAIL query_bypass: got r1=%0b v1=%h, want r1=1 v1=11", out_query_ready1, out_query_value1);
    else passes++;
    tick();
    in_cdb_valid = 0;
    push(0, 5'd3, 4'd0, 32'h10, 0);
    push(0, 5'd4, 4'd1, 32'h11, 0);
    push(0, 5'd5, 4'd2, 32'h22, 0);
    cdb(4'd0, 32'h10, 0, 0);
    drain(10, ok);
    checks++;
    if (!ok || commit_cyc.size() != 3 ||
        commit_cyc[1] - commit_cyc[0] != 1 || commit_cyc[2] - commit_cyc[1] != 1)
      $display("FAIL ooo_back_to_back: got %0d commits pending, %0d seen, want 0 pending and 3 consecutive",
               exp_q.size(), commit_cyc.size());
    else passes++;
  endtask

  task automatic test_store();
    int  quiet;
    bit  ok;
    do_reset();
    issue(5'd0, 1, 32'h40);
    issue(5'd6, 0, 32'h44);
    cdb(4'd1, 32'h66, 0, 0);
    push(1, 5'd0, 4'd0, 0, 0);
    push(0, 5'd6, 4'd1, 32'h66, 0);
    cdb(4'd0, 32'habc, 0, 0);
    for (int i = 0; i < 10 && !store_seen; i++) tick();
    checks++;
    if (!store_seen) $display("FAIL store_pulse: got no store commit, want one for rob 0"); else passes++;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_commit_reg != 0 || out_store_commit) quiet++;
    end
    checks++;
    if (quiet != 0 || exp_q.size() != 1)
      $display("FAIL store_hold: got %0d busy cycles, %0d pending, want 0 and 1", quiet, exp_q.size());
    else passes++;
    in_store_done = 1;
    tick();
    in_store_done = 0;
    tick();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL store_release: got %0d pending one cycle after store_done, want 0", exp_q.size());
    else passes++;
    drain(5, ok);
  endtask

  task automatic test_mispredict();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) issue(5'(i + 1), 0, 32'h200 + 32'(i * 4));
    cdb(4'd3, 32'h33, 0, 0);
    push(0, 5'd1, 4'd0, 32'h10, 0);
    cdb(4'd0, 32'h10, 0, 0);
    push(2, 5'd2, 4'd1, 32'h20, 32'h1000);
    cdb(4'd1, 32'h20, 1, 32'h1000);
    for (int i = 0; i < 10 && !xbp_seen; i++) tick();
    checks++;
    if (!xbp_seen || exp_q.size() != 0)
      $display("FAIL xbp_pulse: got seen=%0b pending=%0d, want seen=1 pending=0", xbp_seen, exp_q.size());
    else passes++;
    // We are now in the flush cycle; this issue must be dropped.
    issue(5'd9, 0, 32'h300);
    checks++;
    if (out_issue_tag !== 4'd0 || out_full !== 1'b0 || out_xbp !== 1'b0)
      $display("FAIL flush_clear: got tag=%0d full=%0b xbp=%0b, want 0/0/0", out_issue_tag, out_full, out_xbp);
    else passes++;
    issue(5'd7, 0, 32'h304);
    push(0, 5'd7, 4'd0, 32'h77, 0);
    cdb(4'd0, 32'h77, 0, 0);
    drain(10, ok);
    checks++;
    if (!ok) $display("FAIL flush_restart: got %0d pending, want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_in_wait_store();
    bit ok;
    do_reset();
    issue(5'd1, 0, 0);
    issue(5'd0, 1, 4);
    push(0, 5'd1, 4'd0, 32'h1, 0);
    cdb(4'd0, 32'h1, 0, 0);
    push(1, 5'd0, 4'd1, 0, 0);
    cdb(4'd1, 32'h0, 0, 0);
    for (int i = 0; i < 10 && !store_seen; i++) tick();
    checks++;
    if (!store_seen) $display("FAIL rstws_pulse: got no store commit, want rob 1"); else passes++;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({out_full, out_issue_tag, out_commit_reg, out_commit_rob, out_store_commit, out_xbp,
         out_commit_value, out_redirect_pc} !== '0)
      $display("FAIL rstws_outputs: got full=%0b tag=%0d reg=%0d rob=%0d st=%0b xbp=%0b val=%h, want all 0",
               out_full, out_issue_tag, out_commit_reg, out_commit_rob, out_store_commit, out_xbp, out_commit_value);
    else passes++;
    issue(5'd8, 0, 0);
    push(0, 5'd8, 4'd0, 32'h88, 0);
    cdb(4'd0, 32'h88, 0, 0);
    drain(10, ok);
    checks++;
    if (!ok) $display("FAIL rstws_run: got %0d pending, want 0", exp_q.size()); else passes++;
  endtask

  initial begin
    rdy = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_ooo();
    test_store();
    test_mispredict();
    test_reset_in_wait_store();
    checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending, want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
In-order reorder-buffer controller that schedules all updates to the architectural register file.
- Allocates ROB tags to the decoder at issue and captures results from the CDB.
- Retires the head entry in program order onto the regfile commit port (reg/rob/value).
- Gates store retirement on an LSB handshake.
- On a mispredicted branch at head, raises the regfile flush (xbp) and the fetch redirect.

Parameters:
- ROB_DEPTH, 16: number of entries; power of two.
- ROB_W, 4: tag width, log2(ROB_DEPTH).
- REG_W, 5: architectural register index width; register 0 means no destination.
- DATA_W, 32: value / PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state frozen and pulse outputs forced low
- in_issue_valid  in  1  decoder issues one instruction this cycle
- in_issue_dest_reg  in  REG_W  destination register (0 = none)
- in_issue_is_store  in  1  instruction is a store
- in_issue_pc  in  DATA_W  instruction PC
- out_issue_tag  out  ROB_W  tag granted = current tail
- out_full  out  1  ROB_DEPTH entries occupied
- in_cdb_valid  in  1  result broadcast
- in_cdb_tag  in  ROB_W  producing entry
- in_cdb_value  in  DATA_W  result value
- in_cdb_mispredict  in  1  branch resolved opposite to prediction
- in_cdb_target  in  DATA_W  correct next PC for the mispredicted branch
- in_query_tag1 / in_query_tag2  in  ROB_W  decoder operand lookup
- out_query_ready1 / out_query_ready2  out  1  entry holds its result
- out_query_value1 / out_query_value2  out  DATA_W  that result
- out_commit_reg  out  REG_W  regfile commit register (0 = nothing)
- out_commit_rob  out  ROB_W  committing tag
- out_commit_value  out  DATA_W  committed value
- out_store_commit  out  1  pulse: LSB may perform the store for out_commit_rob
- in_store_done  in  1  LSB finished the store
- out_xbp  out  1  one-cycle flush pulse to regfile, RS, LSB, fetcher
- out_redirect_pc  out  DATA_W  valid with out_xbp

Behaviour:
- Storage: per entry busy, ready, is_store, mispredict, dest_reg, value, target. Pointers head/tail are ROB_W bits, wrap modulo ROB_DEPTH. count is ROB_W+1 bits.
- Reset: head = tail = count = 0; all busy/ready cleared; state = RUN. Reset outputs: out_full = 0, out_issue_tag = 0, out_commit_reg = 0, out_commit_rob = 0, out_commit_value = 0, out_store_commit = 0, out_xbp = 0, out_redirect_pc = 0, query outputs 0. Reset overrides everything mid-operation, including WAIT_STORE.
- Allocation:
  - out_full = (count == ROB_DEPTH), computed from registered count.
  - If in_issue_valid && !out_full && state != FLUSH: entry[tail] busy = 1, ready = 0, fields written; tail += 1.
  - The decoder must not assert issue while full; if it does, the issue is ignored.
- Writeback: in_cdb_valid with a busy tag sets ready = 1 and stores value, mispredict, target. A CDB to a non-busy tag is ignored.
- Query: combinational. ready = busy && ready, or an in-flight in_cdb_valid with a matching tag (bypass). Value is taken from the CDB when bypassing, else from storage.
- Commit registers (out_commit_*, out_store_commit, out_xbp) are pulses: valid exactly one cycle, otherwise out_commit_reg = 0, out_store_commit = 0, out_xbp = 0.
- State machine:
  - RUN: if the head entry is busy && ready:
    - mispredict: emit commit (reg/value as normal), out_xbp = 1, out_redirect_pc = target; go to FLUSH.
    - is_store: out_store_commit = 1, out_commit_rob = head; go to WAIT_STORE (head not advanced).
    - otherwise: emit out_commit_reg = dest_reg, out_commit_rob = head, out_commit_value = value; clear busy; head += 1.
    - At most one commit per cycle.
  - WAIT_STORE: hold until in_store_done; then clear busy, head += 1, return to RUN. No commit output while waiting.
  - FLUSH (one cycle): head = tail = count = 0, all busy cleared, issue and CDB ignored; return to RUN.
- count update: +1 on accepted allocate, -1 on retire; both in the same cycle leaves count unchanged. Allocation while full is refused even if the head retires that cycle.
- A mispredicted branch with dest_reg != 0 (e.g. JALR) still writes its value to the regfile in the xbp cycle.

Test Plan:
- Reset, then issue x1 (tag 0); CDB tag 0 value 0x5 -> next cycle out_commit_reg = 1, out_commit_rob = 0, out_commit_value = 0x5; count back to 0.
- Issue 16 instructions with no CDB -> out_full = 1 after the 16th; a 17th issue is ignored and tail stays 0 (wrapped). Complete tag 0 -> commit; out_full drops the following cycle.
- Out-of-order completion: tags 0, 1, 2 issued; CDB order 2, 1, 0 -> commits occur tag 0, 1, 2 in consecutive cycles after tag 0 completes.
- Store at head, ready -> out_store_commit pulse with rob = tag; no further commits until in_store_done is asserted 3 cycles later; the next entry commits the cycle after.
- Branch tag 1 mispredicted with target 0x1000, tags 2–4 busy -> out_xbp = 1, out_redirect_pc = 0x1000; one cycle later count = 0; an issue in the FLUSH cycle is ignored, and the next issue gets tag 0.
- rst asserted while in WAIT_STORE -> next cycle all outputs 0, state RUN, count 0.
